regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 5, register index width.
REQ-002 Parameter DATA_WIDTH, default 32, register data width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 a_valid  input  1  requester A (pipeline writeback) has a write pending.
REQ-006 a_addr  input  ADDRESS_WIDTH  requester A destination register.
REQ-007 a_data  input  DATA_WIDTH  requester A write data.
REQ-008 a_ready  output  1  requester A write accepted this cycle.
REQ-009 b_valid  input  1  requester B (multi-cycle unit) has a write pending.
REQ-010 b_addr  input  ADDRESS_WIDTH  requester B destination register.
REQ-011 b_data  input  DATA_WIDTH  requester B write data.
REQ-012 b_ready  output  1  requester B write accepted this cycle.
REQ-013 WE3  output  1  register-file write enable, registered.
REQ-014 AD3  output  ADDRESS_WIDTH  register-file write address, registered.
REQ-015 WD3  output  DATA_WIDTH  register-file write data, registered.
REQ-016 last_b  output  1  round-robin pointer; 1 = B won the most recent contested cycle.
REQ-017 conflicts  output  8  saturating count of contested cycles since reset.

Function
REQ-018 Handshake: transfer on X occurs in a cycle when X_valid and X_ready are both 1; X_ready is combinational from valids and last_b, and never depends on X_ready of the other side.
REQ-019 Only A valid -> a_ready=1, b_ready=0; only B valid -> b_ready=1, a_ready=0; neither -> both 0.
REQ-020 Both valid (contested) -> grant B if last_b=0, else grant A; at most one ready high per cycle.
REQ-021 last_b updates only on contested cycles: set to 1 if B granted, 0 if A granted; uncontested cycles leave it unchanged.
REQ-022 Latency: transfer in cycle N -> WE3=1 with AD3/WD3 equal to granted addr/data in cycle N+1, held for exactly one cycle.
REQ-023 No transfer in cycle N -> WE3=0 in cycle N+1; AD3/WD3 retain previous values.
REQ-024 Writes to address 0 are accepted (ready asserted per REQ-019/020) but produce WE3=0 in cycle N+1; AD3/WD3 still update.
REQ-025 Same-address writes from A and B in consecutive cycles are emitted in grant order; no merging or reordering.
REQ-026 conflicts increments by 1 on each contested cycle and saturates at 255.
REQ-027 Arbitration fairness: with both valid continuously, grants strictly alternate A/B.

Reset
REQ-028 While rst=1 at a rising edge: WE3<=0, AD3<=0, WD3<=0, last_b<=0, conflicts<=0.
REQ-029 While rst=1, a_ready=0 and b_ready=0; no transfer is recorded in that cycle.
REQ-030 Reset asserted in cycle N+1 after a transfer in cycle N forces WE3=0 from the following edge; that write is lost and requesters see no retry indication.
REQ-031 First contested cycle after reset grants B (last_b=0).

Verification
REQ-032 A only: a_valid=1, a_addr=5, a_data=0x1234 for one cycle -> a_ready=1 same cycle; next cycle WE3=1, AD3=5, WD3=0x1234; cycle after WE3=0.
REQ-033 Contention: both valid for 4 cycles after reset, a_addr=1, b_addr=2 -> grants B,A,B,A; WE3 pulses with AD3=2,1,2,1 on cycles 2-5; conflicts=4; last_b=0.
REQ-034 x0 write: b_valid=1, b_addr=0, b_data=0xFFFFFFFF -> b_ready=1; next cycle WE3=0, AD3=0, WD3=0xFFFFFFFF.
REQ-035 Uncontested after contested: contested cycle grants B (last_b=1), then A alone for 3 cycles -> last_b stays 1; next contested cycle grants A.
REQ-036 Reset mid-operation: A transfer in cycle N, rst=1 in cycle N+1 -> WE3=0, AD3=0, WD3=0, a_ready=0 after that edge; last_b=0, conflicts=0.
REQ-037 Saturation: 300 consecutive contested cycles -> conflicts=255, grant alternation unaffected.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write-port arbiter: fixed-latency registered write port,
// round-robin on contention, and a saturating count of contested cycles.
module regfile_write_arbiter #(
  parameter int unsigned ADDRESS_WIDTH = 5,
  parameter int unsigned DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  input  logic [ADDRESS_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0]    a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [ADDRESS_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0]    b_data,
  output logic                     b_ready,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3,
  output logic                     last_b,
  output logic [7:0]               conflicts
);

  logic                     contested;
  logic                     a_fire, b_fire;
  logic                     we_d, we_q;
  logic [ADDRESS_WIDTH-1:0] ad_d, ad_q;
  logic [DATA_WIDTH-1:0]    wd_d, wd_q;
  logic                     last_b_d, last_b_q;
  logic [7:0]               conflicts_d, conflicts_q;

  assign contested = a_valid & b_valid;

  // Readies depend only on the valids and the round-robin pointer.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!rst) begin
      if (contested) begin
        a_ready = last_b_q;
        b_ready = ~last_b_q;
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  assign a_fire = a_valid & a_ready;
  assign b_fire = b_valid & b_ready;

  always_comb begin
    we_d        = 1'b0;
    ad_d        = ad_q;
    wd_d        = wd_q;
    last_b_d    = last_b_q;
    conflicts_d = conflicts_q;
    // x0 writes are accepted and latched, but never enabled.
    if (a_fire) begin
      we_d = (a_addr != '0);
      ad_d = a_addr;
      wd_d = a_data;
    end else if (b_fire) begin
      we_d = (b_addr != '0);
      ad_d = b_addr;
      wd_d = b_data;
    end
    if (contested && !rst) begin
      last_b_d = b_fire;
      if (conflicts_q != 8'hFF) begin
        conflicts_d = conflicts_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q        <= 1'b0;
      ad_q        <= '0;
      wd_q        <= '0;
      last_b_q    <= 1'b0;
      conflicts_q <= 8'd0;
    end else begin
      we_q        <= we_d;
      ad_q        <= ad_d;
      wd_q        <= wd_d;
      last_b_q    <= last_b_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign WE3       = we_q;
  assign AD3       = ad_q;
  assign WD3       = wd_q;
  assign last_b    = last_b_q;
  assign conflicts = conflicts_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic checked against
// a grant-history model of the arbiter.
module tb_regfile_write_arbiter;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_data, b_data;
  logic          a_ready, b_ready;
  logic          WE3;
  logic [AW-1:0] AD3;
  logic [DW-1:0] WD3;
  logic          last_b;
  logic [7:0]    conflicts;

  int total = 0;
  int bad   = 0;

  // Model state: registered write port and the list of contested-cycle winners (1 = B).
  logic          m_we;
  logic [AW-1:0] m_ad;
  logic [DW-1:0] m_wd;
  int            m_conf;
  bit            hist[$];

  regfile_write_arbiter #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a_valid  (a_valid),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .WE3      (WE3),
    .AD3      (AD3),
    .WD3      (WD3),
    .last_b   (last_b),
    .conflicts(conflicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check readies, clock, check registered outputs.
  task automatic step(input logic r, input logic av, input logic [AW-1:0] aa,
                      input logic [DW-1:0] ad, input logic bv, input logic [AW-1:0] ba,
                      input logic [DW-1:0] bd);
    bit ea, eb, exp_lb;
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    if (r) begin
      ea = 0; eb = 0;
    end else if (av && bv) begin
      // B wins unless B took the previous contested cycle.
      eb = (hist.size() == 0) ? 1'b1 : !hist[hist.size()-1];
      ea = !eb;
    end else begin
      ea = av; eb = bv;
    end
    chk("a_ready", {63'd0, a_ready}, {63'd0, ea});
    chk("b_ready", {63'd0, b_ready}, {63'd0, eb});
    @(posedge clk);
    #1;
    if (r) begin
      m_we = 0; m_ad = '0; m_wd = '0; m_conf = 0;
      hist.delete();
    end else begin
      if (ea) begin
        m_we = (aa != 0); m_ad = aa; m_wd = ad;
      end else if (eb) begin
        m_we = (ba != 0); m_ad = ba; m_wd = bd;
      end else begin
        m_we = 0;
      end
      if (av && bv) begin
        hist.push_back(eb);
        if (m_conf < 255) m_conf++;
      end
    end
    exp_lb = (hist.size() == 0) ? 1'b0 : hist[hist.size()-1];
    chk("WE3", {63'd0, WE3}, {63'd0, m_we});
    chk("AD3", {59'd0, AD3}, {59'd0, m_ad});
    chk("WD3", {32'd0, WD3}, {32'd0, m_wd});
    chk("last_b", {63'd0, last_b}, {63'd0, exp_lb});
    chk("conflicts", {56'd0, conflicts}, 64'(m_conf));
  endtask

  task automatic idle();
    step(0, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    m_we = 0; m_ad = '0; m_wd = '0; m_conf = 0;

    // Reset, then A alone writes x5.
    step(1, 1, 5'd3, 32'hDEAD, 1, 5'd4, 32'hBEEF);
    step(1, 0, '0, '0, 0, '0, '0);
    step(0, 1, 5'd5, 32'h1234, 0, '0, '0);
    chk("a_only_we", {63'd0, WE3}, 64'd1);
    chk("a_only_ad", {59'd0, AD3}, 64'd5);
    chk("a_only_wd", {32'd0, WD3}, 64'h1234);
    idle();
    chk("a_only_we_drop", {63'd0, WE3}, 64'd0);

    // Four contested cycles straight after reset: B,A,B,A.
    step(1, 0, '0, '0, 0, '0, '0);
    for (int i = 0; i < 4; i++) step(0, 1, 5'd1, 32'hA0 + i, 1, 5'd2, 32'hB0 + i);
    chk("contest_conf", {56'd0, conflicts}, 64'd4);
    chk("contest_lastb", {63'd0, last_b}, 64'd0);
    idle();

    // x0 write from B: accepted, not enabled, data still latched.
    step(0, 0, '0, '0, 1, 5'd0, 32'hFFFF_FFFF);
    chk("x0_we", {63'd0, WE3}, 64'd0);
    chk("x0_wd", {32'd0, WD3}, 64'hFFFF_FFFF);

    // Contested grants B, then A alone keeps pointer, next contest goes to A.
    step(0, 1, 5'd7, 32'h77, 1, 5'd8, 32'h88);
    for (int i = 0; i < 3; i++) step(0, 1, 5'd9, 32'h90 + i, 0, '0, '0);
    chk("uncont_lastb", {63'd0, last_b}, 64'd1);
    step(0, 1, 5'd10, 32'hAA, 1, 5'd11, 32'hBB);
    chk("uncont_grant_a", {59'd0, AD3}, 64'd10);

    // Reset right after an A transfer drops the write.
    step(0, 1, 5'd12, 32'hC0C0, 0, '0, '0);
    step(1, 1, 5'd13, 32'hD0D0, 0, '0, '0);
    chk("rst_mid_we", {63'd0, WE3}, 64'd0);
    chk("rst_mid_conf", {56'd0, conflicts}, 64'd0);

    // Saturation with same addresses on both sides.
    for (int i = 0; i < 300; i++) step(0, 1, 5'd6, 32'h1000 + i, 1, 5'd6, 32'h2000 + i);
    chk("sat_conf", {56'd0, conflicts}, 64'd255);
    idle();

    // Random traffic, occasional reset, small addresses to hit x0 often.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom(),
           1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
